// File: rtl/i2c_sht40_target.sv
// ---------------------------------------------------------------------------
// i2c_sht40_target
//
// I2C target that behaves like an SHT40 humidity/temperature sensor. It
// acknowledges its 7-bit address and accepts the 0xFD high-precision measure
// command. After a programmable conversion time it serves the 6-byte frame
// T_MSB, T_LSB, CRC, RH_MSB, RH_LSB, CRC to read transactions.
// SCL and SDA are oversampled on the system clock. SDA is only ever pulled
// low and never driven high.
//
// Parameters
//   DEV_ADDR     7-bit target address
//   MEAS_CYCLES  clk cycles from command ACK to data ready (>= 1)
//   SYNC_STAGES  synchronizer depth on scl_in/sda_in (>= 2)
//
// Ports
//   clk          system clock (>= 8x SCL rate)
//   rst_n        asynchronous active-low reset
//   scl_in       sampled SCL line
//   sda_in       sampled SDA line
//   sda_oe       1 = pull SDA low, 0 = release
//   temp_sample  temperature word, latched when the measurement completes
//   rh_sample    humidity word, latched when the measurement completes
//   meas_busy    conversion timer running
//   data_valid   a latched frame is available for reads
//   cmd_strobe   one-cycle pulse when 0xFD is accepted
// ---------------------------------------------------------------------------
module i2c_sht40_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h44,
  parameter int         MEAS_CYCLES = 1000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [15:0] temp_sample,
  input  logic [15:0] rh_sample,
  output logic        meas_busy,
  output logic        data_valid,
  output logic        cmd_strobe
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ADDR      = 3'd1;
  localparam logic [2:0] ST_CMD       = 3'd2;
  localparam logic [2:0] ST_TX        = 3'd3;
  localparam logic [2:0] ST_WAIT_STOP = 3'd4;

  localparam int TW = $clog2(MEAS_CYCLES + 1);
  localparam logic [7:0] CMD_MEASURE_HP = 8'hFD;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic        scl_d, sda_d;
  logic        scl_s, sda_s;
  logic        scl_rise, scl_fall, start_det, stop_det;

  logic [2:0]  state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        ack_phase;
  logic [2:0]  tx_idx;
  logic [TW-1:0] timer;
  logic [15:0] temp_q, rh_q;
  logic [7:0]  crc_t, crc_rh;
  logic [7:0]  tx_byte;
  logic [2:0]  bit_sel;

  // CRC-8, polynomial 0x31, init 0xFF, MSB first, no reflection or final XOR.
  function automatic logic [7:0] crc8(input logic [15:0] word);
    logic [7:0] c;
    c = 8'hFF;
    for (int i = 15; i >= 0; i--) begin
      if (c[7] ^ word[i]) c = {c[6:0], 1'b0} ^ 8'h31;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  // Synchronizers reset to 1 (idle bus is pulled up) so reset release cannot
  // fake a START or STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  // Frame byte currently being shifted out.
  always_comb begin
    tx_byte = 8'hFF;
    case (tx_idx)
      3'd0:    tx_byte = temp_q[15:8];
      3'd1:    tx_byte = temp_q[7:0];
      3'd2:    tx_byte = crc_t;
      3'd3:    tx_byte = rh_q[15:8];
      3'd4:    tx_byte = rh_q[7:0];
      3'd5:    tx_byte = crc_rh;
      default: tx_byte = 8'hFF;
    endcase
  end

  // bit_cnt counts bits already driven, so the next bit is 7 - bit_cnt.
  assign bit_sel = 3'd7 - bit_cnt[2:0];

  // Conversion timer plus bus FSM. The timer can never expire in the same
  // cycle a command is accepted, because a command is accepted only while
  // not busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 8'd0;
      ack_phase  <= 1'b0;
      tx_idx     <= 3'd0;
      sda_oe     <= 1'b0;
      cmd_strobe <= 1'b0;
      meas_busy  <= 1'b0;
      data_valid <= 1'b0;
      timer      <= '0;
      temp_q     <= 16'd0;
      rh_q       <= 16'd0;
      crc_t      <= 8'd0;
      crc_rh     <= 8'd0;
    end else begin
      cmd_strobe <= 1'b0;

      if (meas_busy) begin
        if (timer <= TW'(1)) begin
          meas_busy  <= 1'b0;
          data_valid <= 1'b1;
          timer      <= '0;
          temp_q     <= temp_sample;
          rh_q       <= rh_sample;
          crc_t      <= crc8(temp_sample);
          crc_rh     <= crc8(rh_sample);
        end else begin
          timer <= timer - TW'(1);
        end
      end

      if (start_det) begin
        state     <= ST_ADDR;
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_det) begin
        state     <= ST_IDLE;
        bit_cnt   <= 4'd0;
        ack_phase <= 1'b0;
        sda_oe    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (ack_phase) begin
              // End of our ACK clock: a read starts driving byte 0 right away.
              if (scl_fall) begin
                ack_phase <= 1'b0;
                if (shreg[0]) begin
                  state   <= ST_TX;
                  sda_oe  <= ~tx_byte[7];
                  bit_cnt <= 4'd1;
                end else begin
                  state   <= ST_CMD;
                  sda_oe  <= 1'b0;
                  bit_cnt <= 4'd0;
                end
              end
            end else if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= {shreg[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (shreg[7:1] == DEV_ADDR &&
                  (!shreg[0] || (data_valid && !meas_busy))) begin
                sda_oe    <= 1'b1;
                ack_phase <= 1'b1;
                tx_idx    <= 3'd0;
              end else begin
                state  <= ST_WAIT_STOP;
                sda_oe <= 1'b0;
              end
            end
          end

          ST_CMD: begin
            if (ack_phase) begin
              if (scl_fall) begin
                ack_phase <= 1'b0;
                sda_oe    <= 1'b0;
                state     <= ST_WAIT_STOP;
              end
            end else if (scl_rise && bit_cnt < 4'd8) begin
              shreg   <= {shreg[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (shreg == CMD_MEASURE_HP && !meas_busy) begin
                sda_oe     <= 1'b1;
                ack_phase  <= 1'b1;
                cmd_strobe <= 1'b1;
                data_valid <= 1'b0;
                meas_busy  <= 1'b1;
                timer      <= TW'(MEAS_CYCLES);
              end else begin
                state  <= ST_WAIT_STOP;
                sda_oe <= 1'b0;
              end
            end
          end

          ST_TX: begin
            if (!ack_phase) begin
              if (scl_fall) begin
                if (bit_cnt < 4'd8) begin
                  sda_oe  <= ~tx_byte[bit_sel];
                  bit_cnt <= bit_cnt + 4'd1;
                end else begin
                  sda_oe    <= 1'b0;
                  ack_phase <= 1'b1;
                end
              end
            end else if (scl_rise) begin
              // Master ACK/NACK is sampled here. After byte 5 we stop even on
              // an ACK, because the index never wraps.
              if (!sda_s && tx_idx < 3'd5) tx_idx <= tx_idx + 3'd1;
              else                         state  <= ST_WAIT_STOP;
            end else if (scl_fall) begin
              ack_phase <= 1'b0;
              sda_oe    <= ~tx_byte[7];
              bit_cnt   <= 4'd1;
            end
          end

          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_sht40_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_sht40_target
//
// Directed testbench for i2c_sht40_target. A bit-banged master drives SCL.
// The SDA line is modelled as a wired-AND of the master and target
// pull-downs. Expected bytes and CRCs are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_i2c_sht40_target;

  localparam int MEAS = 400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_scl;
  logic        m_sda_low;
  logic        sda_line;
  logic [15:0] temp_sample, rh_sample;
  logic        sda_oe, meas_busy, data_valid, cmd_strobe;

  int vectors = 0;
  int miscompares = 0;

  int   cycle = 0;
  int   strobe_cnt = 0;
  int   strobe_cyc = 0;
  int   valid_cyc = 0;
  logic dv_prev = 1'b0;

  logic       ack;
  logic       bit_s;
  logic [7:0] rx;
  int         snap;
  logic [7:0] frame_beef [6];
  logic [7:0] frame_zero [6];

  always #5 clk = ~clk;

  assign sda_line = ~(m_sda_low | sda_oe);

  i2c_sht40_target #(
    .DEV_ADDR(7'h44),
    .MEAS_CYCLES(MEAS),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .scl_in(m_scl),
    .sda_in(sda_line),
    .sda_oe(sda_oe),
    .temp_sample(temp_sample),
    .rh_sample(rh_sample),
    .meas_busy(meas_busy),
    .data_valid(data_valid),
    .cmd_strobe(cmd_strobe)
  );

  // Cycle stamps for command strobes and data_valid rising edges.
  always @(posedge clk) begin
    cycle   <= cycle + 1;
    dv_prev <= data_valid;
    if (cmd_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      strobe_cyc <= cycle;
    end
    if (data_valid && !dv_prev) valid_cyc <= cycle;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_clk(4);
    m_scl     = 1'b1; wait_clk(4);
    m_sda_low = 1'b1; wait_clk(4);
    m_scl     = 1'b0; wait_clk(4);
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_clk(4);
    m_scl     = 1'b1; wait_clk(4);
    m_sda_low = 1'b0; wait_clk(4);
  endtask

  task automatic clock_bit(input logic drive_low, output logic sampled);
    m_sda_low = drive_low; wait_clk(4);
    m_scl     = 1'b1;      wait_clk(4);
    sampled   = sda_line;  wait_clk(4);
    m_scl     = 1'b0;      wait_clk(4);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(~b[i], s);
    clock_bit(1'b0, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b0, s);
      b[i] = s;
    end
    clock_bit(master_ack, s);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 2000 && !data_valid; i++) wait_clk(1);
    check_output("valid_timeout", 16'(data_valid), 16'd1);
  endtask

  initial begin
    frame_beef = '{8'hBE, 8'hEF, 8'h92, 8'hBE, 8'hEF, 8'h92};
    frame_zero = '{8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h81};

    rst_n = 1'b0;
    m_scl = 1'b1;
    m_sda_low = 1'b0;
    temp_sample = 16'hBEEF;
    rh_sample   = 16'hBEEF;
    wait_clk(3);
    check_output("rst_sda_oe",     16'(sda_oe),     16'd0);
    check_output("rst_meas_busy",  16'(meas_busy),  16'd0);
    check_output("rst_data_valid", 16'(data_valid), 16'd0);
    check_output("rst_cmd_strobe", 16'(cmd_strobe), 16'd0);
    rst_n = 1'b1;
    wait_clk(5);

    // Measure command with 0xBEEF samples
    snap = strobe_cnt;
    i2c_start();
    write_byte(8'h88, ack);
    check_output("meas_addr_ack", 16'(ack), 16'd1);
    write_byte(8'hFD, ack);
    check_output("meas_cmd_ack", 16'(ack), 16'd1);
    i2c_stop();
    check_output("meas_strobe_once", 16'(strobe_cnt - snap), 16'd1);
    check_output("meas_busy_set",    16'(meas_busy),  16'd1);
    check_output("meas_valid_clr",   16'(data_valid), 16'd0);

    // Read while busy: address NACK, SDA stays released
    i2c_start();
    write_byte(8'h89, ack);
    check_output("busy_read_nack", 16'(ack), 16'd0);
    read_byte(1'b0, rx);
    check_output("busy_read_released", 16'(rx), 16'hFF);
    i2c_stop();
    check_output("busy_still_busy",  16'(meas_busy),  16'd1);
    check_output("busy_valid_low",   16'(data_valid), 16'd0);

    wait_valid();
    wait_clk(2);
    check_output("meas_latency", 16'(valid_cyc - strobe_cyc), 16'(MEAS));
    check_output("meas_busy_clr", 16'(meas_busy), 16'd0);

    // Full frame read, then extra clocking past byte 5
    i2c_start();
    write_byte(8'h89, ack);
    check_output("read_addr_ack", 16'(ack), 16'd1);
    for (int i = 0; i < 6; i++) begin
      read_byte(logic'(i < 5), rx);
      check_output($sformatf("beef_b%0d", i), 16'(rx), 16'(frame_beef[i]));
    end
    read_byte(1'b0, rx);
    check_output("past_byte5_released", 16'(rx), 16'hFF);
    i2c_stop();
    check_output("valid_persists", 16'(data_valid), 16'd1);

    // Wrong address, then wrong command
    snap = strobe_cnt;
    i2c_start();
    write_byte(8'h90, ack);
    check_output("addr48_nack", 16'(ack), 16'd0);
    i2c_stop();
    i2c_start();
    write_byte(8'h88, ack);
    check_output("badcmd_addr_ack", 16'(ack), 16'd1);
    write_byte(8'h94, ack);
    check_output("badcmd_nack", 16'(ack), 16'd0);
    i2c_stop();
    check_output("badcmd_no_strobe", 16'(strobe_cnt - snap), 16'd0);
    check_output("badcmd_valid_kept", 16'(data_valid), 16'd1);

    // Zero samples: early NACK, then repeated START for the full frame
    temp_sample = 16'h0000;
    rh_sample   = 16'h0000;
    i2c_start();
    write_byte(8'h88, ack);
    write_byte(8'hFD, ack);
    check_output("zero_cmd_ack", 16'(ack), 16'd1);
    i2c_stop();
    wait_valid();
    i2c_start();
    write_byte(8'h89, ack);
    check_output("zero_addr_ack", 16'(ack), 16'd1);
    read_byte(1'b1, rx);
    check_output("zero_short_b0", 16'(rx), 16'h00);
    read_byte(1'b0, rx);
    check_output("zero_short_b1", 16'(rx), 16'h00);
    check_output("zero_nack_release", 16'(sda_oe), 16'd0);
    i2c_start();
    write_byte(8'h89, ack);
    check_output("rstart_addr_ack", 16'(ack), 16'd1);
    for (int i = 0; i < 6; i++) begin
      read_byte(logic'(i < 5), rx);
      check_output($sformatf("zero_b%0d", i), 16'(rx), 16'(frame_zero[i]));
    end
    i2c_stop();

    // Async reset mid-TX while the master also pulls SDA low
    i2c_start();
    write_byte(8'h89, ack);
    check_output("rstx_addr_ack", 16'(ack), 16'd1);
    clock_bit(1'b0, bit_s);
    m_sda_low = 1'b1;
    check_output("rstx_driving", 16'(sda_oe), 16'd1);
    rst_n = 1'b0;
    #1;
    check_output("rstx_sda_oe",     16'(sda_oe),     16'd0);
    check_output("rstx_meas_busy",  16'(meas_busy),  16'd0);
    check_output("rstx_data_valid", 16'(data_valid), 16'd0);
    check_output("rstx_cmd_strobe", 16'(cmd_strobe), 16'd0);
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    i2c_stop();
    i2c_start();
    write_byte(8'h89, ack);
    check_output("post_rst_read_nack", 16'(ack), 16'd0);
    i2c_stop();
    check_output("post_rst_valid", 16'(data_valid), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
